// File: rtl/arashi_pkg.sv
// Shared types and width helpers for the arashi drain scheduler.
package arashi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CAPT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    function automatic int thread_num(input int tw);
        return 1 << tw;
    endfunction

    function automatic int region_width(input int mw, input int tw);
        return mw - tw;
    endfunction

endpackage

// File: rtl/arashi_rr_pick.sv
// Cyclic priority pick: first asserted request at or after start, wrapping mod N.
module arashi_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         vld
);

    logic [W-1:0] cand;

    // N is a power of two, so W-bit addition wraps the scan naturally.
    always_comb begin
        idx  = '0;
        vld  = 1'b0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            cand = start + W'(k);
            if (!vld && req[cand]) begin
                idx = cand;
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arashi_drain_sched.sv
// Round-robin drain of per-thread cache words into per-thread memory regions.
// Define ARASHI_DRAIN_WRAP_EN to make region pointers wrap instead of saturating.
module arashi_drain_sched
    import arashi_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int MEM_WIDTH        = 10,
    parameter int THREAD_NUM_WIDTH = 2,
    localparam int THREAD_NUM      = thread_num(THREAD_NUM_WIDTH),
    localparam int REGION_WIDTH    = region_width(MEM_WIDTH, THREAD_NUM_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [THREAD_NUM-1:0]       avail,
    output logic [THREAD_NUM_WIDTH-1:0] toread,
    output logic                        rcache,
    input  logic [DATA_WIDTH-1:0]       cache_data,
    input  logic [THREAD_NUM-1:0]       clr,
    output logic                        mem_we,
    output logic [MEM_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    input  logic                        mem_ready,
    output logic [THREAD_NUM-1:0]       full,
    output logic                        busy
);

    if (THREAD_NUM_WIDTH < 2 || THREAD_NUM_WIDTH > 4) begin : g_bad_width
        $error("arashi_drain_sched: THREAD_NUM_WIDTH must be in 2..4");
    end

    state_t                        state, state_nxt;
    logic [THREAD_NUM_WIDTH-1:0]   rr_ptr;
    logic [REGION_WIDTH-1:0]       wptr [THREAD_NUM];
    logic [THREAD_NUM_WIDTH-1:0]   pick_idx;
    logic                          pick_vld;
    logic                          handshake;

    arashi_rr_pick #(
        .N (THREAD_NUM),
        .W (THREAD_NUM_WIDTH)
    ) u_pick (
        .req   (avail & ~full),
        .start (rr_ptr),
        .idx   (pick_idx),
        .vld   (pick_vld)
    );

    // mem_we is high for the whole of WRITE, so the handshake is just ready in WRITE.
    assign handshake = (state == WRITE) && mem_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = READ;
            READ:    state_nxt = CAPT;
            CAPT:    state_nxt = WRITE;
            WRITE:   if (mem_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // toread doubles as the latched grant for the rest of the transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcache    <= 1'b0;
            toread    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
            full      <= '0;
            for (int i = 0; i < THREAD_NUM; i++) wptr[i] <= '0;
        end else begin
            rcache <= (state == IDLE) && pick_vld;
            busy   <= (state_nxt != IDLE);
            if ((state == IDLE) && pick_vld) toread <= pick_idx;
            if (state == CAPT) begin
                mem_wdata <= cache_data;
                mem_we    <= 1'b1;
                mem_addr  <= {toread, wptr[toread]};
            end
            if (handshake) begin
                mem_we <= 1'b0;
                rr_ptr <= toread + THREAD_NUM_WIDTH'(1);
            end
            // A clear wins over a coincident pointer advance for the same thread.
            for (int i = 0; i < THREAD_NUM; i++) begin
                if (clr[i]) begin
                    wptr[i] <= '0;
                    full[i] <= 1'b0;
                end else if (handshake && toread == THREAD_NUM_WIDTH'(i)) begin
`ifdef ARASHI_DRAIN_WRAP_EN
                    wptr[i] <= wptr[i] + REGION_WIDTH'(1);
`else
                    if (&wptr[i]) full[i] <= 1'b1;
                    else          wptr[i] <= wptr[i] + REGION_WIDTH'(1);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_arashi_drain_sched.sv
// Directed self-checking bench for arashi_drain_sched (default 32-bit data, 10-bit address, 4 threads).
module tb_arashi_drain_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  avail;
    logic [1:0]  toread;
    logic        rcache;
    logic [31:0] cache_data;
    logic [3:0]  clr;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [3:0]  full;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    arashi_drain_sched #(
        .DATA_WIDTH       (32),
        .MEM_WIDTH        (10),
        .THREAD_NUM_WIDTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .avail      (avail),
        .toread     (toread),
        .rcache     (rcache),
        .cache_data (cache_data),
        .clr        (clr),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .full       (full),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_we(input string tag);
        int n = 0;
        while (mem_we !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_we_seen"}, 64'(mem_we), 64'd1);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        avail = '0;
        clr   = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rcache"}, 64'(rcache),    64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we),    64'd0);
        chk({tag, "_toread"}, 64'(toread),    64'd0);
        chk({tag, "_addr"},   64'(mem_addr),  64'd0);
        chk({tag, "_wdata"},  64'(mem_wdata), 64'd0);
        chk({tag, "_full"},   64'(full),      64'd0);
        chk({tag, "_busy"},   64'(busy),      64'd0);
    endtask

    logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [9:0] exp_a [5] = '{10'h000, 10'h100, 10'h200, 10'h300, 10'h001};

    initial begin
        int prev;
        rst = 1'b1; avail = '0; clr = '0; mem_ready = 1'b0; cache_data = '0;
        tick(); tick();
        chk_reset_vals("rst");
        rst = 1'b0;

        // single request, minimum latency
        avail = 4'b0100; mem_ready = 1'b1; cache_data = 32'h1111_2222;
        tick();
        chk("single_rcache", 64'(rcache), 64'd1);
        chk("single_toread", 64'(toread), 64'd2);
        chk("single_busy",   64'(busy),   64'd1);
        avail = '0;
        tick();
        chk("single_rcache_pulse", 64'(rcache), 64'd0);
        chk("single_we_early",     64'(mem_we), 64'd0);
        tick();
        chk("single_we",    64'(mem_we),    64'd1);
        chk("single_addr",  64'(mem_addr),  64'h200);
        chk("single_wdata", 64'(mem_wdata), 64'h1111_2222);
        tick();
        chk("single_we_done", 64'(mem_we), 64'd0);
        chk("single_idle",    64'(busy),   64'd0);
        avail = 4'b0100; cache_data = 32'h3333_4444;
        wait_we("single2");
        chk("single2_addr",  64'(mem_addr),  64'h201);
        chk("single2_wdata", 64'(mem_wdata), 64'h3333_4444);
        avail = '0;
        tick();

        // fairness with all threads requesting
        do_reset();
        avail = 4'b1111; mem_ready = 1'b1;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            cache_data = 32'hF000_0000 + 32'(k);
            wait_we("fair");
            chk("fair_grant", 64'(toread),    64'(exp_g[k]));
            chk("fair_addr",  64'(mem_addr),  64'(exp_a[k]));
            chk("fair_wdata", 64'(mem_wdata), 64'hF000_0000 + 64'(k));
            if (k > 0) chk("fair_period", 64'(cyc - prev), 64'd4);
            prev = cyc;
            tick();
        end
        avail = '0;
        tick();

        // backpressure holds the write stable
        do_reset();
        avail = 4'b0001; mem_ready = 1'b0; cache_data = 32'hDEAD_BEEF;
        wait_we("bp");
        avail = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_we",     64'(mem_we),    64'd1);
            chk("bp_addr",   64'(mem_addr),  64'h000);
            chk("bp_wdata",  64'(mem_wdata), 64'hDEAD_BEEF);
            chk("bp_rcache", 64'(rcache),    64'd0);
        end
        mem_ready = 1'b1;
        tick();
        chk("bp_release", 64'(mem_we), 64'd0);
        avail = 4'b0001; cache_data = 32'h0BAD_F00D;
        wait_we("bp2");
        chk("bp2_addr", 64'(mem_addr), 64'h001);
        avail = '0;
        tick();

        // saturation of thread 1
        do_reset();
        avail = 4'b0010; mem_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            cache_data = 32'h5A00_0000 + 32'(k);
            wait_we("sat");
            chk("sat_addr", 64'(mem_addr), 64'h100 + 64'(k));
            tick();
        end
`ifdef ARASHI_DRAIN_WRAP_EN
        chk("wrap_full", 64'(full), 64'd0);
        wait_we("wrap");
        chk("wrap_addr", 64'(mem_addr), 64'h100);
        avail = '0;
        tick();
        chk("wrap_full_after", 64'(full), 64'd0);
`else
        chk("sat_full", 64'(full), 64'b0010);
        avail = 4'b0011;
        wait_we("sat_t0");
        chk("sat_t0_grant", 64'(toread),   64'd0);
        chk("sat_t0_addr",  64'(mem_addr), 64'h000);
        tick();
        wait_we("sat_t0b");
        chk("sat_t0b_grant", 64'(toread),   64'd0);
        chk("sat_t0b_addr",  64'(mem_addr), 64'h001);
        avail = '0;
        tick();
        clr = 4'b0010;
        tick();
        clr = '0;
        chk("sat_clr_full", 64'(full), 64'd0);
        avail = 4'b0010;
        wait_we("sat_after_clr");
        chk("sat_after_clr_addr", 64'(mem_addr), 64'h100);
        avail = '0;
        tick();
`endif

        // clr coincident with handshake, then clr mid-transaction
        do_reset();
        avail = 4'b1000; mem_ready = 1'b0;
        wait_we("clr_hs");
        chk("clr_hs_addr", 64'(mem_addr), 64'h300);
        avail = '0; mem_ready = 1'b1; clr = 4'b1000;
        tick();
        clr = '0;
        chk("clr_hs_done", 64'(mem_we), 64'd0);
        avail = 4'b1000;
        wait_we("clr_hs_ptr");
        chk("clr_hs_ptr_addr", 64'(mem_addr), 64'h300);
        avail = '0;
        tick();
        avail = 4'b1000; mem_ready = 1'b0;
        wait_we("clr_mid");
        chk("clr_mid_addr", 64'(mem_addr), 64'h301);
        avail = '0; clr = 4'b1000;
        tick();
        clr = '0; mem_ready = 1'b1;
        chk("clr_mid_hold", 64'(mem_addr), 64'h301);
        tick();
        avail = 4'b1000;
        wait_we("clr_mid_next");
        chk("clr_mid_next_addr", 64'(mem_addr), 64'h301);
        avail = '0;
        tick();

        // reset during WRITE
        avail = 4'b0100; mem_ready = 1'b0; cache_data = 32'hABCD_0123;
        wait_we("rst_wr");
        chk("rst_wr_toread", 64'(toread), 64'd2);
        rst = 1'b1; avail = '0;
        tick();
        chk_reset_vals("rst_wr");
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/arashi_drain_sched.md
# arashi_drain_sched

Round-robin scheduler that drains per-thread cache entries into a partitioned shared memory. It sits between the per-thread write cache and the memory write port, deciding which thread's cached word is read out and where it lands. It issues the cache read strobe and thread select, captures the returned word, and performs the memory write under ready/valid backpressure. Each thread owns a private memory region with its own write pointer and full flag.

## Interface
- DATA_WIDTH, 32, cache/memory word width
- MEM_WIDTH, 10, memory address width
- THREAD_NUM_WIDTH, 2, log2 of thread count; legal range 2..4 (elaboration error otherwise); THREAD_NUM = 1 << THREAD_NUM_WIDTH
- REGION_WIDTH (localparam) = MEM_WIDTH - THREAD_NUM_WIDTH, per-thread pointer width
---
- clk  in  1  system clock; sole clock
- rst  in  1  synchronous reset, active-high
- avail  in  THREAD_NUM  cache holds a word for thread i
- toread  out  THREAD_NUM_WIDTH  thread selected for cache read
- rcache  out  1  one-cycle cache read strobe
- cache_data  in  DATA_WIDTH  cache read data, valid the cycle after rcache
- clr  in  THREAD_NUM  pulse: reset thread i's write pointer and full flag
- mem_we  out  1  memory write valid
- mem_addr  out  MEM_WIDTH  {thread id, region pointer}
- mem_wdata  out  DATA_WIDTH  write data
- mem_ready  in  1  memory accepts write when mem_we & mem_ready
- full  out  THREAD_NUM  thread i's region exhausted
- busy  out  1  FSM not in IDLE

## Operation
- FSM states IDLE, READ, CAPT, WRITE.
- IDLE: eligible[i] = avail[i] & ~full[i]. If any eligible, latch grant = first eligible index at or after rr_ptr (cyclic), go READ; else stay.
- READ: rcache=1, toread=grant for exactly one cycle; go CAPT.
- CAPT: register cache_data into mem_wdata; go WRITE.
- WRITE: mem_we=1, mem_addr={grant, wptr[grant]}; hold all three stable until mem_ready. On handshake: wptr[grant]++, rr_ptr = grant+1 (mod THREAD_NUM), go IDLE.
- Pointer reaching all-ones region address and being written: full[grant] set, wptr stays at all-ones (no wrap, default build).
- full threads ignored by arbitration; their avail remains pending in cache.
- clr[i]: next cycle wptr[i]=0, full[i]=0. clr on same cycle as handshake for same thread: clr wins. clr of a thread mid-transaction does not abort it; the write completes to the address already presented, then pointer update is suppressed by clr if coincident, applied otherwise.
- avail not re-sampled outside IDLE; toread held at last grant between reads.

## Timing
- Reset values: rcache=0, mem_we=0, toread=0, mem_addr=0, mem_wdata=0, full=0, busy=0; rr_ptr=0, all wptr=0, state IDLE.
- All outputs registered.
- Minimum avail-to-mem_we latency: avail high in cycle N (IDLE) -> rcache in N+1 -> capture N+2 -> mem_we in N+3.
- Peak throughput: one word per 4 cycles with mem_ready tied high.
- rst mid-transaction: abort immediately to reset values; word lost from cache remains cache's concern (already consumed if rcache fired).

## Configuration
- ARASHI_DRAIN_WRAP_EN defined: region pointers wrap from all-ones to 0; full never asserts (held 0), all avail threads always eligible; clr still zeroes pointer.
- Undefined: saturating behaviour with full flags as above.

## Structure
- Shared package arashi_pkg: state enum (IDLE/READ/CAPT/WRITE), THREAD_NUM and REGION_WIDTH derivation functions.
- One sub-module: arashi_rr_pick (combinational cyclic priority pick, THREAD_NUM-wide request vector + start pointer -> index + valid).

## Test plan
- Single request: avail=4'b0100, mem_ready=1 -> rcache at +1 with toread=2, mem_we at +3, mem_addr=0x200, wptr[2]=1.
- Fairness: avail=4'b1111 held -> grant order 0,1,2,3,0 with mem_addr 0x000,0x100,0x200,0x300,0x001.
- Backpressure: mem_ready=0 for 5 cycles in WRITE -> mem_we/mem_addr/mem_wdata stable, no new rcache, write on cycle ready rises.
- Saturation: 256 writes thread 1 -> full[1]=1, further avail[1] ignored while avail[0] still served; clr[1] -> full[1]=0, next address 0x100. With ARASHI_DRAIN_WRAP_EN: 257th write at 0x100, full stays 0.
- clr coincident with handshake for thread 3 -> wptr[3]=0 afterward; rst asserted in WRITE -> all outputs at reset values next cycle.
